// File: rtl/agc_timing_pkg.sv
// Shared types and default sizing for the AGC timing-pulse generator.
// Latency: n/a (types only). Backpressure: n/a.
// Defaults describe a 12-pulse memory cycle with an 8-bit cycle counter.
package agc_timing_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } tp_state_e;

    localparam int NUM_TP_DEFAULT = 12;
    localparam int MCT_W_DEFAULT  = 8;

endpackage

// File: rtl/agc_tp_decode.sv
// Turns a time-pulse index plus busy flag into a one-hot pulse vector.
// Latency: combinational; the parent registers the result. Backpressure: none.
// Out-of-range indices and idle both decode to all-zero.
module agc_tp_decode #(
    parameter int NUM_TP = 12,
    parameter int IDX_W  = 4
) (
    input  logic [IDX_W-1:0]  idx,
    input  logic              busy,
    output logic [NUM_TP-1:0] tp
);

    always_comb begin
        tp = '0;
        for (int i = 0; i < NUM_TP; i++) begin
            tp[i] = busy && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/agc_timepulse_gen.sv
// AGC time-pulse generator: one-hot TP1..TPn per memory cycle, run/step modes, hold stretch.
// Latency: outputs registered; a run/step sampled in IDLE shows TP1 the following cycle.
// Backpressure: hold freezes the current pulse and markers for as long as it is high.
module agc_timepulse_gen
    import agc_timing_pkg::*;
#(
    parameter  int NUM_TP = NUM_TP_DEFAULT,
    parameter  int MCT_W  = MCT_W_DEFAULT,
    localparam int IDX_W  = $clog2(NUM_TP)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              step,
    input  logic              hold,
    output logic [NUM_TP-1:0] tp,
    output logic [IDX_W-1:0]  tp_idx,
    output logic              cycle_start,
    output logic              cycle_end,
    output logic [MCT_W-1:0]  mct_count,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TP - 1);

    tp_state_e         state;
    tp_state_e         state_nxt;
    logic [IDX_W-1:0]  idx_nxt;
    logic              mct_inc;
    logic              busy_nxt;
    logic              start_nxt;
    logic              end_nxt;
    logic [NUM_TP-1:0] tp_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            tp_idx      <= '0;
            tp          <= '0;
            cycle_start <= 1'b0;
            cycle_end   <= 1'b0;
            busy        <= 1'b0;
            mct_count   <= '0;
        end else begin
            state       <= state_nxt;
            tp_idx      <= idx_nxt;
            tp          <= tp_nxt;
            cycle_start <= start_nxt;
            cycle_end   <= end_nxt;
            busy        <= busy_nxt;
            if (mct_inc) begin
                mct_count <= mct_count + MCT_W'(1);
            end
        end
    end

    // A cycle always runs to TPn once started; run is only consulted at TPn.
    always_comb begin
        state_nxt = state;
        idx_nxt   = tp_idx;
        mct_inc   = 1'b0;
        case (state)
            IDLE: begin
                idx_nxt = '0;
                if (run) begin
                    state_nxt = RUN;
                end else if (step) begin
                    state_nxt = STEP;
                end
            end
            RUN, STEP: begin
                if (tp_idx > LAST_IDX) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else if (!hold) begin
                    if (tp_idx == LAST_IDX) begin
                        mct_inc   = 1'b1;
                        idx_nxt   = '0;
                        state_nxt = run ? RUN : IDLE;
                    end else begin
                        idx_nxt = tp_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        busy_nxt  = (state_nxt != IDLE);
        start_nxt = busy_nxt && (idx_nxt == '0);
        end_nxt   = busy_nxt && (idx_nxt == LAST_IDX);
    end

    agc_tp_decode #(
        .NUM_TP (NUM_TP),
        .IDX_W  (IDX_W)
    ) u_decode (
        .idx  (idx_nxt),
        .busy (busy_nxt),
        .tp   (tp_nxt)
    );

endmodule

// File: tb/tb_agc_timepulse_gen.sv
// Directed bench for agc_timepulse_gen: a vector table for free-run, then hand sequences
// for step, hold, run-drop, step-to-run, async reset and a 9-pulse / 2-bit counter instance.
module tb_agc_timepulse_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run, step, hold;
    logic [11:0] tp;
    logic [3:0]  tp_idx;
    logic        cycle_start, cycle_end, busy;
    logic [7:0]  mct_count;

    logic        run9, step9, hold9;
    logic [8:0]  tp9;
    logic [3:0]  tp_idx9;
    logic        cycle_start9, cycle_end9, busy9;
    logic [1:0]  mct_count9;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        run;
        logic        step;
        logic        hold;
        logic [11:0] tp;
        logic [3:0]  idx;
        logic        cs;
        logic        ce;
        logic [7:0]  mct;
        logic        busy;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    int hold_idx [15] = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 6, 7, 8, 9, 10, 11};

    agc_timepulse_gen #(.NUM_TP(12), .MCT_W(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .step        (step),
        .hold        (hold),
        .tp          (tp),
        .tp_idx      (tp_idx),
        .cycle_start (cycle_start),
        .cycle_end   (cycle_end),
        .mct_count   (mct_count),
        .busy        (busy)
    );

    agc_timepulse_gen #(.NUM_TP(9), .MCT_W(2)) dut9 (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run9),
        .step        (step9),
        .hold        (hold9),
        .tp          (tp9),
        .tp_idx      (tp_idx9),
        .cycle_start (cycle_start9),
        .cycle_end   (cycle_end9),
        .mct_count   (mct_count9),
        .busy        (busy9)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic [11:0] etp, input logic [3:0] eidx,
                             input logic ecs, input logic ece, input logic [7:0] emct,
                             input logic ebusy);
        cmp({nm, ".tp"},    32'(tp),          32'(etp));
        cmp({nm, ".idx"},   32'(tp_idx),      32'(eidx));
        cmp({nm, ".start"}, 32'(cycle_start), 32'(ecs));
        cmp({nm, ".end"},   32'(cycle_end),   32'(ece));
        cmp({nm, ".mct"},   32'(mct_count),   32'(emct));
        cmp({nm, ".busy"},  32'(busy),        32'(ebusy));
    endtask

    task automatic check9(input string nm, input logic [8:0] etp, input logic [3:0] eidx,
                          input logic ecs, input logic ece, input logic [1:0] emct,
                          input logic ebusy);
        cmp({nm, ".tp"},    32'(tp9),          32'(etp));
        cmp({nm, ".idx"},   32'(tp_idx9),      32'(eidx));
        cmp({nm, ".start"}, 32'(cycle_start9), 32'(ecs));
        cmp({nm, ".end"},   32'(cycle_end9),   32'(ece));
        cmp({nm, ".mct"},   32'(mct_count9),   32'(emct));
        cmp({nm, ".busy"},  32'(busy9),        32'(ebusy));
    endtask

    task automatic go(input logic r, input logic s, input logic h);
        run  = r;
        step = s;
        hold = h;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Free-run table: two back-to-back cycles, run drops at the second TP12, then hold in IDLE.
        for (int k = 0; k < 24; k++) begin
            vecs[k].run  = 1'b1;
            vecs[k].step = 1'b0;
            vecs[k].hold = 1'b0;
            vecs[k].tp   = 12'(1) << (k % 12);
            vecs[k].idx  = 4'(k % 12);
            vecs[k].cs   = (k % 12) == 0;
            vecs[k].ce   = (k % 12) == 11;
            vecs[k].mct  = 8'(k / 12);
            vecs[k].busy = 1'b1;
        end
        vecs[24] = '{run: 1'b0, step: 1'b0, hold: 1'b0, tp: 12'h000, idx: 4'd0,
                     cs: 1'b0, ce: 1'b0, mct: 8'd2, busy: 1'b0};
        vecs[25] = '{run: 1'b0, step: 1'b0, hold: 1'b1, tp: 12'h000, idx: 4'd0,
                     cs: 1'b0, ce: 1'b0, mct: 8'd2, busy: 1'b0};

        reset_n = 1'b0;
        run = 1'b0; step = 1'b0; hold = 1'b0;
        run9 = 1'b0; step9 = 1'b0; hold9 = 1'b0;
        #12;
        check_all("reset", 12'h000, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0);
        check9("reset9", 9'h000, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("idle", 12'h000, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            go(vecs[i].run, vecs[i].step, vecs[i].hold);
            check_all($sformatf("vec%0d", i), vecs[i].tp, vecs[i].idx, vecs[i].cs,
                      vecs[i].ce, vecs[i].mct, vecs[i].busy);
        end

        // Single step; a second step pulse during TP4 must be ignored.
        for (int k = 0; k < 12; k++) begin
            go(1'b0, (k == 0 || k == 4), 1'b0);
            check_all($sformatf("step%0d", k), 12'(1) << k, 4'(k), k == 0, k == 11, 8'd2, 1'b1);
        end
        go(1'b0, 1'b0, 1'b0);
        check_all("step_end", 12'h000, 4'd0, 1'b0, 1'b0, 8'd3, 1'b0);
        go(1'b0, 1'b0, 1'b0);
        check_all("step_idle", 12'h000, 4'd0, 1'b0, 1'b0, 8'd3, 1'b0);

        // Hold three clocks at TP5; run drops mid-cycle after the hold.
        for (int j = 0; j < 15; j++) begin
            go(j < 8, 1'b0, (j >= 5 && j <= 7));
            check_all($sformatf("hold%0d", j), 12'(1) << hold_idx[j], 4'(hold_idx[j]),
                      hold_idx[j] == 0, hold_idx[j] == 11, 8'd3, 1'b1);
        end
        go(1'b0, 1'b0, 1'b0);
        check_all("hold_end", 12'h000, 4'd0, 1'b0, 1'b0, 8'd4, 1'b0);

        // Run dropped at TP3, then hold stretches TP12 and its end marker.
        for (int j = 0; j < 13; j++) begin
            go(j < 3, 1'b0, j == 12);
            check_all($sformatf("drop%0d", j), 12'(1) << ((j < 12) ? j : 11),
                      4'((j < 12) ? j : 11), j == 0, j >= 11, 8'd4, 1'b1);
        end
        go(1'b0, 1'b0, 1'b0);
        check_all("drop_end", 12'h000, 4'd0, 1'b0, 1'b0, 8'd5, 1'b0);

        // Step cycle with run high at its TP12 continues straight into a run cycle.
        for (int j = 0; j < 24; j++) begin
            go(j == 12, j == 0, 1'b0);
            check_all($sformatf("s2r%0d", j), 12'(1) << (j % 12), 4'(j % 12),
                      (j % 12) == 0, (j % 12) == 11, (j < 12) ? 8'd5 : 8'd6, 1'b1);
        end
        go(1'b0, 1'b0, 1'b0);
        check_all("s2r_end", 12'h000, 4'd0, 1'b0, 1'b0, 8'd7, 1'b0);

        // Asynchronous reset in the middle of TP7.
        for (int j = 0; j < 7; j++) begin
            go(1'b1, 1'b0, 1'b0);
        end
        check_all("pre_rst", 12'h040, 4'd6, 1'b0, 1'b0, 8'd7, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("rst_async", 12'h000, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0);
        go(1'b1, 1'b0, 1'b0);
        check_all("rst_held", 12'h000, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0);
        reset_n = 1'b1;
        go(1'b1, 1'b0, 1'b0);
        check_all("rst_tp1", 12'h001, 4'd0, 1'b1, 1'b0, 8'd0, 1'b1);
        for (int j = 1; j < 12; j++) begin
            go(1'b0, 1'b0, 1'b0);
        end
        check_all("rst_tp12", 12'h800, 4'd11, 1'b0, 1'b1, 8'd0, 1'b1);
        go(1'b0, 1'b0, 1'b0);
        check_all("rst_end", 12'h000, 4'd0, 1'b0, 1'b0, 8'd1, 1'b0);

        // Nine-pulse instance with a 2-bit counter, five cycles.
        for (int k = 0; k < 45; k++) begin
            run9 = 1'b1;
            @(posedge clk);
            #1;
            check9($sformatf("n9_%0d", k), 9'(1) << (k % 9), 4'(k % 9), (k % 9) == 0,
                   (k % 9) == 8, 2'((k / 9) % 4), 1'b1);
        end
        run9 = 1'b0;
        @(posedge clk);
        #1;
        check9("n9_end", 9'h000, 4'd0, 1'b0, 1'b0, 2'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
